// File: rtl/mem_wb_multi_pkg.sv
// Shared definitions for the multi-lane MEM/WB register.
// Lane field widths and offsets live here with the legacy constants.
package mem_wb_multi_pkg;

  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic        ZeroBit  = 1'b0;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;

  localparam int         RN_W     = 5;
  localparam logic [4:0] REG_ZERO = 5'b0;

  function automatic int d_off(input int k, input int dw);
    return k * dw;
  endfunction

  function automatic int rn_off(input int k);
    return k * RN_W;
  endfunction

endpackage

// File: rtl/mem_wb_lane_qual.sv
// Combinational kill, write-enable qualification and
// same-cycle write-conflict masking across all lanes.
module mem_wb_lane_qual
  import mem_wb_multi_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]      i_valid,
  input  logic [LANES-1:0]      i_excp,
  input  logic [LANES*DW-1:0]   i_d1,
  input  logic [LANES*DW-1:0]   i_d2,
  input  logic [LANES*RN_W-1:0] i_rn,
  input  logic [LANES-1:0]      i_write_regfile,
  input  logic [LANES-1:0]      i_mem_to_regfile,
  output logic [LANES-1:0]      q_valid,
  output logic [LANES*DW-1:0]   q_d1,
  output logic [LANES*DW-1:0]   q_d2,
  output logic [LANES*RN_W-1:0] q_rn,
  output logic [LANES-1:0]      q_write_regfile,
  output logic [LANES-1:0]      q_mem_to_regfile
);

  logic             kill;
  logic [LANES-1:0] pre_we;

  always_comb begin
    kill             = ZeroBit;
    pre_we           = '0;
    q_valid          = '0;
    q_d1             = '0;
    q_d2             = '0;
    q_rn             = '0;
    q_mem_to_regfile = '0;
    // lane 0 is oldest: an excepting lane kills everything after it
    for (int k = 0; k < LANES; k++) begin
      if (!kill && i_valid[k]) begin
        q_valid[k] = 1'b1;
        q_d1[d_off(k, DW) +: DW] = i_d1[d_off(k, DW) +: DW];
        q_d2[d_off(k, DW) +: DW] = i_d2[d_off(k, DW) +: DW];
        q_rn[rn_off(k) +: RN_W] = i_rn[rn_off(k) +: RN_W];
        q_mem_to_regfile[k] = i_mem_to_regfile[k];
        pre_we[k] = i_write_regfile[k] && !i_excp[k] &&
                    (i_rn[rn_off(k) +: RN_W] != REG_ZERO);
        if (i_excp[k])
          kill = 1'b1;
      end
    end
  end

  // youngest writer to a register wins
  always_comb begin
    q_write_regfile = pre_we;
    for (int j = 0; j < LANES; j++) begin
      for (int k = j + 1; k < LANES; k++) begin
        if (pre_we[j] && pre_we[k] &&
            q_rn[rn_off(j) +: RN_W] == q_rn[rn_off(k) +: RN_W])
          q_write_regfile[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM/WB stage register with flush, bubble insertion
// and a saturating bubble counter.
module mem_wb_multi
  import mem_wb_multi_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LANES = 2,
  parameter int STAGE = 4,
  parameter int SW    = 6,
  parameter int CW    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW-1:0]         stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  input  logic [LANES-1:0]      i_valid,
  input  logic [LANES-1:0]      i_excp,
  input  logic [LANES*DW-1:0]   i_d1,
  input  logic [LANES*DW-1:0]   i_d2,
  input  logic [LANES*5-1:0]    i_rn,
  input  logic [LANES-1:0]      i_write_regfile,
  input  logic [LANES-1:0]      i_mem_to_regfile,
  output logic [LANES-1:0]      o_valid,
  output logic [LANES*DW-1:0]   o_d1,
  output logic [LANES*DW-1:0]   o_d2,
  output logic [LANES*5-1:0]    o_rn,
  output logic [LANES-1:0]      o_write_regfile,
  output logic [LANES-1:0]      o_mem_to_regfile,
  output logic [CW-1:0]         o_bubble_cnt
);

  logic [LANES-1:0]    q_valid;
  logic [LANES*DW-1:0] q_d1;
  logic [LANES*DW-1:0] q_d2;
  logic [LANES*5-1:0]  q_rn;
  logic [LANES-1:0]    q_we;
  logic [LANES-1:0]    q_m2r;
  logic                hold;
  logic                bubble;
  logic                stall_unused;

  assign hold   = (stall[STAGE] == Stop);
  assign bubble = hold && (stall[STAGE+1] == NoStop);
  assign stall_unused = ^stall;

  mem_wb_lane_qual #(
    .DW    (DW),
    .LANES (LANES)
  ) u_qual (
    .i_valid          (i_valid),
    .i_excp           (i_excp),
    .i_d1             (i_d1),
    .i_d2             (i_d2),
    .i_rn             (i_rn),
    .i_write_regfile  (i_write_regfile),
    .i_mem_to_regfile (i_mem_to_regfile),
    .q_valid          (q_valid),
    .q_d1             (q_d1),
    .q_d2             (q_d2),
    .q_rn             (q_rn),
    .q_write_regfile  (q_we),
    .q_mem_to_regfile (q_m2r)
  );

  always_ff @(posedge clk) begin
    if (reset || flush || bubble) begin
      o_valid          <= '0;
      o_d1             <= '0;
      o_d2             <= '0;
      o_rn             <= '0;
      o_write_regfile  <= '0;
      o_mem_to_regfile <= '0;
    end else if (!hold) begin
      o_valid          <= q_valid;
      o_d1             <= q_d1;
      o_d2             <= q_d2;
      o_rn             <= q_rn;
      o_write_regfile  <= q_we;
      o_mem_to_regfile <= q_m2r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr)
      o_bubble_cnt <= '0;
    else if (bubble && !flush && o_bubble_cnt != {CW{1'b1}})
      o_bubble_cnt <= o_bubble_cnt + 1'b1;
  end

endmodule

// File: tb/tb_mem_wb_multi.sv
// Directed checks of the multi-lane MEM/WB register.
// Table of single-cycle captures plus hold/bubble/flush/counter sequences.
module tb_mem_wb_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic        cnt_clr;
  logic [1:0]  i_valid;
  logic [1:0]  i_excp;
  logic [63:0] i_d1;
  logic [63:0] i_d2;
  logic [9:0]  i_rn;
  logic [1:0]  i_we;
  logic [1:0]  i_m2r;

  logic [1:0]  o_valid, o_we, o_m2r;
  logic [63:0] o_d1, o_d2;
  logic [9:0]  o_rn;
  logic [15:0] o_cnt;

  logic [1:0]  s_valid, s_we, s_m2r;
  logic [63:0] s_d1, s_d2;
  logic [9:0]  s_rn;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_multi dut (
    .clk (clk), .reset (reset), .stall (stall), .flush (flush),
    .cnt_clr (cnt_clr), .i_valid (i_valid), .i_excp (i_excp),
    .i_d1 (i_d1), .i_d2 (i_d2), .i_rn (i_rn),
    .i_write_regfile (i_we), .i_mem_to_regfile (i_m2r),
    .o_valid (o_valid), .o_d1 (o_d1), .o_d2 (o_d2), .o_rn (o_rn),
    .o_write_regfile (o_we), .o_mem_to_regfile (o_m2r),
    .o_bubble_cnt (o_cnt)
  );

  mem_wb_multi #(.CW(2)) dut_sat (
    .clk (clk), .reset (reset), .stall (stall), .flush (flush),
    .cnt_clr (cnt_clr), .i_valid (i_valid), .i_excp (i_excp),
    .i_d1 (i_d1), .i_d2 (i_d2), .i_rn (i_rn),
    .i_write_regfile (i_we), .i_mem_to_regfile (i_m2r),
    .o_valid (s_valid), .o_d1 (s_d1), .o_d2 (s_d2), .o_rn (s_rn),
    .o_write_regfile (s_we), .o_mem_to_regfile (s_m2r),
    .o_bubble_cnt (s_cnt)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  v;
    logic [1:0]  ex;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [9:0]  rn;
    logic [1:0]  we;
    logic [1:0]  m2r;
    logic [1:0]  ev;
    logic [63:0] ed1;
    logic [63:0] ed2;
    logic [9:0]  ern;
    logic [1:0]  ewe;
    logic [1:0]  em2r;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [63:0] w2(input logic [31:0] a, input logic [31:0] b);
    return {a, b};
  endfunction

  function automatic logic [9:0] r2(input logic [4:0] a, input logic [4:0] b);
    return {a, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [159:0] outs();
    return {o_valid, o_d1, o_d2, o_rn, o_we, o_m2r};
  endfunction

  task automatic apply(input vec_t t);
    stall   = t.stall;
    flush   = t.flush;
    i_valid = t.v;
    i_excp  = t.ex;
    i_d1    = t.d1;
    i_d2    = t.d2;
    i_rn    = t.rn;
    i_we    = t.we;
    i_m2r   = t.m2r;
  endtask

  task automatic chk_vec(input string nm, input vec_t t);
    chk(nm, outs(), {t.ev, t.ed1, t.ed2, t.ern, t.ewe, t.em2r});
  endtask

  initial begin
    reset = 1'b1; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
    i_valid = '0; i_excp = '0; i_d1 = '0; i_d2 = '0;
    i_rn = '0; i_we = '0; i_m2r = '0;

    // capture
    vecs[0] = '{6'h00, 1'b0, 2'b11, 2'b00, w2(32'h22, 32'h11),
                w2(32'hB2, 32'hA1), r2(5'd4, 5'd3), 2'b11, 2'b01,
                2'b11, w2(32'h22, 32'h11), w2(32'hB2, 32'hA1),
                r2(5'd4, 5'd3), 2'b11, 2'b01};
    // lane0 exception kills lane1
    vecs[1] = '{6'h00, 1'b0, 2'b11, 2'b01, w2(32'h55, 32'h33),
                w2(32'h66, 32'h44), r2(5'd5, 5'd2), 2'b11, 2'b11,
                2'b01, w2(32'h0, 32'h33), w2(32'h0, 32'h44),
                r2(5'd0, 5'd2), 2'b00, 2'b01};
    // same-rn conflict
    vecs[2] = '{6'h00, 1'b0, 2'b11, 2'b00, w2(32'h77, 32'h70),
                w2(32'h0, 32'h0), r2(5'd7, 5'd7), 2'b11, 2'b00,
                2'b11, w2(32'h77, 32'h70), w2(32'h0, 32'h0),
                r2(5'd7, 5'd7), 2'b10, 2'b00};
    // write to r0 dropped
    vecs[3] = '{6'h00, 1'b0, 2'b11, 2'b00, w2(32'h9, 32'h8),
                w2(32'h1, 32'h2), r2(5'd6, 5'd0), 2'b11, 2'b10,
                2'b11, w2(32'h9, 32'h8), w2(32'h1, 32'h2),
                r2(5'd6, 5'd0), 2'b10, 2'b10};
    // invalid lane0 zeroed
    vecs[4] = '{6'h00, 1'b0, 2'b10, 2'b00, w2(32'hAA, 32'hBB),
                w2(32'hCC, 32'hDD), r2(5'd9, 5'd1), 2'b11, 2'b11,
                2'b10, w2(32'hAA, 32'h0), w2(32'hCC, 32'h0),
                r2(5'd9, 5'd0), 2'b10, 2'b10};
    // lane1 exception: no conflict against a suppressed writer
    vecs[5] = '{6'h00, 1'b0, 2'b11, 2'b10, w2(32'h1, 32'h2),
                w2(32'h3, 32'h4), r2(5'd8, 5'd8), 2'b11, 2'b00,
                2'b11, w2(32'h1, 32'h2), w2(32'h3, 32'h4),
                r2(5'd8, 5'd8), 2'b01, 2'b00};
    // exception on invalid lane0 ignored
    vecs[6] = '{6'h00, 1'b0, 2'b10, 2'b01, w2(32'h5, 32'h6),
                w2(32'h0, 32'h0), r2(5'd3, 5'd3), 2'b11, 2'b00,
                2'b10, w2(32'h5, 32'h0), w2(32'h0, 32'h0),
                r2(5'd3, 5'd0), 2'b10, 2'b00};
    // flush beats capture
    vecs[7] = '{6'h00, 1'b1, 2'b11, 2'b00, w2(32'h22, 32'h11),
                w2(32'hB2, 32'hA1), r2(5'd4, 5'd3), 2'b11, 2'b01,
                2'b00, 64'h0, 64'h0, 10'h0, 2'b00, 2'b00};
    // no writers
    vecs[8] = '{6'h00, 1'b0, 2'b11, 2'b00, w2(32'hF, 32'hE),
                w2(32'h0, 32'h0), r2(5'd2, 5'd1), 2'b00, 2'b00,
                2'b11, w2(32'hF, 32'hE), w2(32'h0, 32'h0),
                r2(5'd2, 5'd1), 2'b00, 2'b00};
    // lower-bit stall is not ours: capture proceeds
    vecs[9] = '{6'h0F, 1'b0, 2'b01, 2'b00, w2(32'h0, 32'h1234),
                w2(32'h0, 32'h5678), r2(5'd0, 5'd31), 2'b01, 2'b01,
                2'b01, w2(32'h0, 32'h1234), w2(32'h0, 32'h5678),
                r2(5'd0, 5'd31), 2'b01, 2'b01};

    step();
    step();
    chk("reset_outs", outs(), 160'h0);
    chk("reset_cnt", {144'h0, o_cnt}, 160'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      step();
      chk_vec($sformatf("vec%0d", i), vecs[i]);
    end
    flush = 1'b0;
    chk("cnt_after_table", {144'h0, o_cnt}, 160'h0);

    // hold for 3 cycles while inputs change, then bubble
    apply(vecs[0]);
    step();
    apply(vecs[2]);
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_vec($sformatf("hold%0d", i), vecs[0]);
    end
    stall = 6'b010000;
    step();
    chk("bubble_outs", outs(), 160'h0);
    chk("bubble_cnt", {144'h0, o_cnt}, 160'h1);

    // flush with valid inputs: zero and no count
    apply(vecs[0]);
    flush = 1'b1;
    step();
    chk("flush_outs", outs(), 160'h0);
    chk("flush_cnt", {144'h0, o_cnt}, 160'h1);

    // flush during a bubble-stall does not count
    flush = 1'b1;
    stall = 6'b010000;
    step();
    chk("flush_bubble_cnt", {144'h0, o_cnt}, 160'h1);

    // flush ends a hold
    apply(vecs[0]);
    step();
    chk_vec("reload", vecs[0]);
    stall = 6'b110000;
    step();
    flush = 1'b1;
    step();
    chk("flush_hold", outs(), 160'h0);

    // saturation of the 2-bit counter
    flush = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat_reset", {158'h0, s_cnt}, 160'h0);
    stall = 6'b010000;
    for (int i = 0; i < 5; i++)
      step();
    chk("sat_cnt", {158'h0, s_cnt}, 160'h3);
    chk("wide_cnt", {144'h0, o_cnt}, 160'h5);
    cnt_clr = 1'b1;
    step();
    chk("clr_sat", {158'h0, s_cnt}, 160'h0);
    chk("clr_wide", {144'h0, o_cnt}, 160'h0);
    cnt_clr = 1'b0;
    step();
    chk("count_after_clr", {144'h0, o_cnt}, 160'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
- Parametrised successor of the single-lane MEM/WB register, for the dual-issue core.
- Carries LANES parallel write-back slots from MEM to WB under the global stall vector.
- Adds, beyond a plain pipeline register:
  - per-lane valid,
  - exception flush,
  - kill of younger lanes on an exception,
  - same-cycle write-conflict resolution,
  - a saturating bubble counter for performance monitoring.

Parameters:
- DW, 32, width of each data field (d1, d2) per lane.
- LANES, 2, number of issue lanes; 1..4. Lane 0 is oldest.
- STAGE, 4, bit of stall owned by this register; bubble test uses STAGE+1.
- SW, 6, stall vector width; must satisfy STAGE+1 < SW.
- CW, 16, bubble counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  SW  global stall vector; 1 = Stop.
- flush  in  1  exception flush from CP0.
- cnt_clr  in  1  clears bubble counter.
- i_valid  in  LANES  lane holds a real instruction.
- i_excp  in  LANES  lane raised an exception in MEM.
- i_d1  in  LANES*DW  ALU result per lane; lane k at bits [k*DW +: DW].
- i_d2  in  LANES*DW  memory load data per lane, same packing as i_d1.
- i_rn  in  LANES*5  destination register per lane.
- i_write_regfile  in  LANES  per-lane write enable.
- i_mem_to_regfile  in  LANES  per-lane select of d2 over d1.
- o_valid  out  LANES  registered valid.
- o_d1, o_d2  out  LANES*DW  registered data.
- o_rn  out  LANES*5  registered destination register.
- o_write_regfile  out  LANES  registered, qualified write enable.
- o_mem_to_regfile  out  LANES  registered select.
- o_bubble_cnt  out  CW  number of bubbles inserted.

Behaviour:
- All outputs are registered on posedge clk; latency is 1 cycle.
- Reset: every output is 0, including o_bubble_cnt.
- Stage-register update priority, highest first:
  - reset → all lane fields 0.
  - flush → all lane fields 0, regardless of stall.
  - Bubble: stall[STAGE]=1 and stall[STAGE+1]=0 → all lane fields 0.
  - Hold: stall[STAGE]=1 and stall[STAGE+1]=1 → all outputs keep their value.
  - Capture: stall[STAGE]=0 → load the qualified inputs below.
- Capture qualification:
  - Let e be the lowest lane with i_valid[e] & i_excp[e].
  - Lanes above e are killed: all fields 0.
  - Lane e itself is captured with o_write_regfile[e]=0.
  - Unkilled lane k:
    - o_valid[k] = i_valid[k].
    - o_write_regfile[k] = i_write_regfile[k] & i_valid[k] & (i_rn[k] != 0).
    - Remaining fields are copied.
- Write conflict: if lanes j<k would both assert write to the same rn after qualification, clear o_write_regfile[j]. The youngest writer wins. Data fields are unchanged.
- Any lane with o_valid=0 has every other field 0.
- Bubble counter:
  - Increments by 1 on each bubble cycle.
  - Does not increment on flush or reset cycles.
  - Saturates at 2^CW-1.
  - cnt_clr zeroes it, with priority over increment.
  - Reset clears it.
- Reset, flush or bubble arriving during a hold ends the hold immediately; the held data is discarded.

Decomposition:
- Shared defines header (already in use) supplies ZeroWord, ZeroBit, Stop and NoStop.
- Add to the header: the lane field offsets and a REG_ZERO constant (5'b0).
- One sub-module, mem_wb_lane_qual: combinational kill, enable qualification and conflict masking for all lanes.
- The top level keeps only the registers and the counter.

Test Plan:
- Capture: LANES=2, stall=0, lane0 rn=3 d1=0x11, lane1 rn=4 d1=0x22, both valid and writing → next cycle both lanes appear, both o_write_regfile=1.
- Hold/bubble:
  - Load, then stall=6'b110000 for 3 cycles → outputs unchanged.
  - Then stall=6'b010000 → all outputs zero and o_bubble_cnt=1.
- Flush priority: flush=1 together with stall=0 and valid inputs → outputs zero, counter unchanged.
- Exception kill: lane0 i_excp=1, lane1 valid writing rn=5 → o_valid=2'b01, o_write_regfile=2'b00, lane1 fields zero.
- Conflict and r0:
  - Both lanes write rn=7 → o_write_regfile=2'b10.
  - Lane0 rn=0 with write=1 → o_write_regfile[0]=0.
- Counter saturation: CW=2, 5 bubble cycles → o_bubble_cnt=3; then cnt_clr=1 with a bubble → 0.
